// File: rtl/oram_path_server.sv
// oram_path_server: memory-side responder for a tree-based ORAM controller.
// Holds the whole bucket tree on chip and serves PATH_READ / PATH_WRITE
// commands, one bucket per level, root first.
// Optional build macro: ORAM_PATH_SERVER_INVALIDATE_ON_READ_EN
//   defined   -> each bucket accepted on the read port has its tuple valid
//                bits cleared in storage (path removed on read)
//   undefined -> reads are non-destructive
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | sweeping the tree, clearing tuple valid bits, busy=1
// S_IDLE  | waiting for a command, cmd_ready=1
// S_READ  | streaming path buckets on the rd_* port
// S_WRITE | accepting path buckets on the wr_* port
module oram_path_server #(
  parameter int A_BYTES = 8,
  parameter int D       = 6,
  parameter int K       = 3,
  localparam int TUPLE_W = 2*D + 8*A_BYTES + 2,
  localparam int BW      = K*TUPLE_W,
  localparam int LW      = $clog2(D),
  localparam int NODES   = (1 << D) - 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [D-2:0]  cmd_leaf,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [BW-1:0] rd_data,
  output logic [LW-1:0] rd_level,
  output logic          rd_last,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [BW-1:0] wr_data,
  output logic          done
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_WRITE} state_t;

  localparam logic [LW-1:0] LAST_LVL = LW'(D - 1);
  localparam logic [D-1:0]  LAST_IDX = D'(NODES - 1);

  state_t        state, next_state;
  logic [BW-1:0] mem [0:NODES-1];
  logic [D-1:0]  clr_idx;
  logic [D-2:0]  leaf;
  logic [D-1:0]  node;   // heap-numbered node of the current level (root = 1)
  logic [D-1:0]  nxt;
  logic [LW-1:0] level;

  // child on the path: leaf bits are consumed LSB first, one per level
  assign nxt = {node[D-2:0], leaf[level]};

  // state register; reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= next_state;
  end

  // next-state and handshake outputs
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    rd_valid   = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_idx == LAST_IDX) next_state = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = cmd_write ? S_WRITE : S_READ;
      end
      S_READ: begin
        rd_valid = 1'b1;
        if (rd_ready && rd_last) next_state = S_IDLE;
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && level == LAST_LVL) next_state = S_IDLE;
      end
      default: next_state = S_CLEAR;
    endcase
  end

  // path walk, registered read port and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx  <= '0;
      leaf     <= '0;
      node     <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_level <= '0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_CLEAR: clr_idx <= clr_idx + 1'b1;
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            leaf  <= cmd_leaf;
            node  <= D'(1);
            level <= '0;
            if (!cmd_write) begin
              rd_data  <= mem[0];
              rd_level <= '0;
              rd_last  <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (rd_ready) begin
            if (rd_last) begin
              rd_last <= 1'b0;
              done    <= 1'b1;
            end else begin
              node     <= nxt;
              level    <= level + 1'b1;
              rd_data  <= mem[nxt - 1'b1];
              rd_level <= level + 1'b1;
              rd_last  <= (level + 1'b1 == LAST_LVL);
            end
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            if (level == LAST_LVL) begin
              done <= 1'b1;
            end else begin
              node  <= nxt;
              level <= level + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // bucket storage: clear sweep, path writes, optional invalidate on read
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      for (int j = 0; j < K; j++) mem[clr_idx][j*TUPLE_W] <= 1'b0;
    end else if (!rst) begin
      if (state == S_WRITE && wr_valid) mem[node - 1'b1] <= wr_data;
`ifdef ORAM_PATH_SERVER_INVALIDATE_ON_READ_EN
      if (state == S_READ && rd_ready) begin
        for (int j = 0; j < K; j++) mem[node - 1'b1][j*TUPLE_W] <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_oram_path_server.sv
// tb_oram_path_server: table-driven command sequence against a storage model,
// with a scoreboard of expected read buckets and hand-written reset/abort cases.
module tb_oram_path_server;
  localparam int A_BYTES = 8;
  localparam int D       = 6;
  localparam int K       = 3;
  localparam int TW      = 2*D + 8*A_BYTES + 2;
  localparam int BW      = K*TW;
  localparam int NODES   = (1 << D) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [D-2:0]  cmd_leaf;
  logic          rd_valid, rd_ready, rd_last;
  logic [BW-1:0] rd_data;
  logic [2:0]    rd_level;
  logic          wr_valid, wr_ready;
  logic [BW-1:0] wr_data;
  logic          done;

  oram_path_server #(.A_BYTES(A_BYTES), .D(D), .K(K)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_leaf(cmd_leaf),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_level(rd_level), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int            level;
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit           wr;
    logic [D-2:0] leaf;
    logic [3:0]   pat;    // rd_ready per cycle, LSB first, repeating
    int           seed;   // 0 = 0x1000+level pattern, else random buckets
    int           gap;    // level before which wr_valid idles one cycle (-1 none)
    bit           noise;  // drive wr_valid garbage during a read
  } op_t;

  logic [BW-1:0] mdl [NODES];
  bit            known [NODES];
  logic [BW-1:0] vmask;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic int path_idx(input logic [D-2:0] leaf, input int l);
    int n = 1;
    for (int i = 1; i <= l; i++) n = 2*n + int'(leaf[i-1]);
    return n - 1;
  endfunction

  function automatic logic [BW-1:0] gen(input int seed, input int l);
    logic [BW-1:0]  b;
    logic [255:0]   t;
    b = '0;
    if (seed == 0) begin
      b[0]      = 1'b1;
      b[1]      = 1'b1;
      b[2 +: 64] = 64'h1000 + 64'(l);
    end else begin
      for (int c = 0; c < 8; c++) t[c*32 +: 32] = $urandom;
      b = t[BW-1:0];
    end
    return b;
  endfunction

  function automatic int exp_cycles(input logic [3:0] pat);
    int cnt = 0;
    int c = 0;
    while (cnt < D) begin
      if (pat[c % 4]) cnt++;
      c++;
    end
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NODES; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end
  endtask

  task automatic push_read(input logic [D-2:0] leaf);
    exp_t e;
    int   idx;
    for (int l = 0; l < D; l++) begin
      idx     = path_idx(leaf, l);
      e.level = l;
      e.data  = mdl[idx];
      e.mask  = known[idx] ? {BW{1'b1}} : vmask;
      sbq.push_back(e);
`ifdef ORAM_PATH_SERVER_INVALIDATE_ON_READ_EN
      mdl[idx] = mdl[idx] & ~vmask;
`endif
    end
  endtask

  task automatic check_clear();
    int cnt = 0;
    int bad = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cmd_ready || rd_valid || wr_ready || done || rd_last || rd_level != 0 || rd_data != '0) bad++;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, 63);
    chk("clear_outputs_zero", bad, 0);
    chk("busy_after_clear", busy, 1'b0);
    chk("cmd_ready_after_clear", cmd_ready, 1'b1);
  endtask

  task automatic run_read(input logic [D-2:0] leaf, input logic [3:0] pat, input bit noise);
    int            cyc = 0;
    int            got = 0;
    int            early = 0;
    bit            stall = 0;
    logic [BW-1:0] hd;
    logic [2:0]    hl;
    exp_t          e;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_leaf = leaf;
    push_read(leaf);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_leaf = D'($urandom);
    chk("cmd_ready_in_read", cmd_ready, 1'b0);
    chk("rd_valid_first", rd_valid, 1'b1);
    while (got < D && cyc < 64) begin
      if (stall) begin
        chk("rd_hold_data", rd_data, hd);
        chk("rd_hold_level", rd_level, hl);
        chk("rd_hold_valid", rd_valid, 1'b1);
      end
      rd_ready = pat[cyc % 4];
      if (noise) begin
        wr_valid = 1'b1;
        wr_data  = gen(1, 0);
      end
      stall = rd_valid && !rd_ready;
      hd = rd_data;
      hl = rd_level;
      if (rd_valid && rd_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("rd_level", rd_level, e.level);
          chk("rd_data", rd_data & e.mask, e.data & e.mask);
          chk("rd_last", rd_last, e.level == D-1);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
      if (got < D && done) early++;
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    chk("read_complete", got, D);
    chk("read_cycles", cyc, exp_cycles(pat));
    chk("read_done_early", early, 0);
    chk("read_done_pulse", done, 1'b1);
    chk("rd_valid_drop", rd_valid, 1'b0);
    @(negedge clk);
    chk("read_done_single", done, 1'b0);
    chk("sb_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  // abort_at >= 0 asserts rst at that level instead of writing it
  task automatic run_write(input logic [D-2:0] leaf, input int seed, input int gap, input int abort_at);
    int idx;
    int early = 0;
    @(negedge clk);
    chk("cmd_ready_idle_w", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_leaf = leaf;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_leaf = D'($urandom);
    chk("rd_valid_in_write", rd_valid, 1'b0);
    for (int l = 0; l < D; l++) begin
      if (l == abort_at) begin
        rst = 1'b1; wr_valid = 1'b1; wr_data = gen(seed, l);
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        chk("abort_no_done", done, 1'b0);
        chk("abort_busy", busy, 1'b1);
        model_clear();
        return;
      end
      if (l == gap) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("done_in_gap", done, 1'b0);
      end
      chk("wr_ready", wr_ready, 1'b1);
      wr_valid = 1'b1;
      wr_data  = gen(seed, l);
      idx = path_idx(leaf, l);
      mdl[idx]   = wr_data;
      known[idx] = 1'b1;
      @(negedge clk);
      if (l < D-1 && done) early++;
    end
    wr_valid = 1'b0;
    chk("write_done_early", early, 0);
    chk("write_done_pulse", done, 1'b1);
    chk("wr_ready_drop", wr_ready, 1'b0);
    @(negedge clk);
    chk("write_done_single", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t ops[7];
    ops[0] = '{1'b1, 5'b00101, 4'hF, 0, -1, 1'b0};
    ops[1] = '{1'b0, 5'b00101, 4'hF, 0, -1, 1'b0};
    ops[2] = '{1'b0, 5'b00101, 4'b1001, 0, -1, 1'b0};
    ops[3] = '{1'b0, 5'b11111, 4'hF, 0, -1, 1'b0};
    ops[4] = '{1'b1, 5'b11010, 4'hF, 7, 2, 1'b0};
    ops[5] = '{1'b0, 5'b11010, 4'b0110, 0, -1, 1'b1};
    ops[6] = '{1'b0, 5'b00000, 4'b1101, 0, -1, 1'b0};

    vmask = '0;
    for (int j = 0; j < K; j++) vmask[j*TW] = 1'b1;
    model_clear();

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_leaf = '0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b1);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_last", rd_last, 1'b0);
    chk("reset_rd_level", rd_level, 3'd0);
    chk("reset_rd_data", rd_data, '0);
    chk("reset_wr_ready", wr_ready, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    check_clear();

    for (int i = 0; i < 7; i++) begin
      if (ops[i].wr) run_write(ops[i].leaf, ops[i].seed, ops[i].gap, -1);
      else           run_read(ops[i].leaf, ops[i].pat, ops[i].noise);
    end

    // reset in the middle of a PATH_WRITE: sweep reruns, nothing survives
    run_write(5'b01100, 0, -1, 3);
    check_clear();
    run_read(5'b01100, 4'hF, 1'b0);
    run_read(5'b00101, 4'hF, 1'b0);
    run_read(5'b11010, 4'b1011, 1'b0);

    // spec example again: write then two reads (second is invalid when reads destroy)
    run_write(5'b00101, 0, -1, -1);
    run_read(5'b00101, 4'hF, 1'b0);
    run_read(5'b00101, 4'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
